// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr
// N-input priority encoder with a registered result and a valid/ready output handshake.
// mode=0 picks the highest set request index. mode=1 picks in round-robin order: the
// search descends from ptr-1 modulo N, and ptr remembers the last round-robin winner.
// All outputs come straight from flops, so no combinational path runs from req/en/mode.
module priority_encoder_rr #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [N-1:0]    req,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [IDXW-1:0] out_idx,
  output logic [N-1:0]    out_onehot
);

  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [IDXW-1:0]   ptr_r;
  logic [IDXW-1:0]   idx_r;
  logic [N-1:0]      onehot_r;
  logic [IDXW-1:0]   base_s;
  logic [IDXW-1:0]   winner_s;
  logic              load_s;

  // The search visits base-1, base-2, ..., base (modulo N). The loop runs from the
  // lowest priority to the highest, so the last set request it finds is the winner.
  function automatic logic [IDXW-1:0] pick_winner(input logic [N-1:0]    r,
                                                  input logic [IDXW-1:0] base);
    logic [IDXW-1:0] win;
    int              j;
    win = {IDXW{1'b0}};
    for (int k = N; k >= 1; k--) begin
      j = int'(base) + N - k;
      j = (j >= N) ? (j - N) : j;
      if (r[SELW'(j)]) begin
        win = IDXW'(j);
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  // Winner selection and the load decision. With base 0 the search order matches fixed mode.
  always_comb begin
    base_s   = mode ? ptr_r : {IDXW{1'b0}};
    winner_s = pick_winner(req, base_s);
    load_s   = en && (req != {N{1'b0}}) && ((state_r == EMPTY) || out_ready);
  end

  // Next-state logic for the EMPTY/FULL output slot.
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (load_s) begin
          state_s = FULL;
        end else begin
          state_s = EMPTY;
        end
      end
      FULL: begin
        if (load_s) begin
          state_s = FULL;
        end else if (out_ready) begin
          state_s = EMPTY;
        end else begin
          state_s = FULL;
        end
      end
      default: state_s = EMPTY;
    endcase
  end

  // State register. Reset clears any pending result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Result and round-robin pointer registers. They change only when a new winner loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r    <= {IDXW{1'b0}};
      onehot_r <= {N{1'b0}};
      ptr_r    <= {IDXW{1'b0}};
    end else if (load_s) begin
      idx_r    <= winner_s;
      onehot_r <= {{(N-1){1'b0}}, 1'b1} << winner_s;
      ptr_r    <= mode ? winner_s : ptr_r;
    end
  end

  assign out_valid  = (state_r == FULL);
  assign out_idx    = idx_r;
  assign out_onehot = onehot_r;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb_priority_encoder_rr
// Table-driven bench for priority_encoder_rr (N=8). Each vector is applied for one
// cycle, and its expected result goes into a scoreboard queue. After the edge, that
// entry is popped and compared with the registered outputs.
module tb_priority_encoder_rr;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;

  typedef struct {
    logic       en;
    logic       mode;
    logic [7:0] req;
    logic       rdy;
    logic       valid;
    logic [2:0] idx;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [2:0] idx;
    logic [7:0] oh;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[0:27];
  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_miss = 0;

  priority_encoder_rr #(.N(8), .IDXW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .req        (req),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_onehot (out_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic e, input logic m, input logic [7:0] r,
                              input logic rd, input logic v, input logic [2:0] i);
    vec_t x;
    x.en = e; x.mode = m; x.req = r; x.rdy = rd; x.valid = v; x.idx = i;
    return x;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int n);
    exp_t       e;
    logic [7:0] one;
    one       = 8'h01;
    en        = v.en;
    mode      = v.mode;
    req       = v.req;
    out_ready = v.rdy;
    e.valid   = v.valid;
    e.idx     = v.idx;
    e.oh      = one << v.idx;
    sb.push_back(e);
    n_vec++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_miss++;
      $display("FAIL sb_empty vec %0d: got 0 entries, expected 1", n);
    end else begin
      e = sb.pop_front();
      cmp($sformatf("vec%0d valid", n), 32'(out_valid), 32'(e.valid));
      cmp($sformatf("vec%0d idx", n), 32'(out_idx), 32'(e.idx));
      cmp($sformatf("vec%0d onehot", n), 32'(out_onehot), 32'(e.oh));
    end
  endtask

  initial begin
    //            en    mode  req     rdy   valid idx
    // Round-robin over all requests, starting from ptr=0.
    tbl[0]  = mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'd7);
    tbl[1]  = mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'd6);
    tbl[2]  = mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'd5);
    tbl[3]  = mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'd4);
    tbl[4]  = mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'd3);
    tbl[5]  = mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'd2);
    tbl[6]  = mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'd1);
    tbl[7]  = mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'd0);
    tbl[8]  = mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'd7);
    // Round-robin alternation between bit 0 and bit 7.
    tbl[9]  = mk(1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 3'd0);
    tbl[10] = mk(1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 3'd7);
    tbl[11] = mk(1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 3'd0);
    // Fixed priority (ptr=0 here).
    tbl[12] = mk(1'b1, 1'b0, 8'h7E, 1'b1, 1'b1, 3'd6);
    tbl[13] = mk(1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 3'd0);
    // A round-robin load sets ptr=3, a fixed load keeps it, and the next RR load picks 2.
    tbl[14] = mk(1'b1, 1'b1, 8'h0C, 1'b1, 1'b1, 3'd3);
    tbl[15] = mk(1'b1, 1'b0, 8'h0C, 1'b1, 1'b1, 3'd3);
    tbl[16] = mk(1'b1, 1'b1, 8'h0C, 1'b1, 1'b1, 3'd2);
    // Backpressure holds idx 5 while the inputs change. An accept with req=0 then empties.
    tbl[17] = mk(1'b1, 1'b0, 8'h20, 1'b1, 1'b1, 3'd5);
    tbl[18] = mk(1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 3'd5);
    tbl[19] = mk(1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 3'd5);
    tbl[20] = mk(1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 3'd5);
    tbl[21] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd5);
    // en=0 blocks the load, then en=1 loads.
    tbl[22] = mk(1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 3'd5);
    tbl[23] = mk(1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 3'd5);
    tbl[24] = mk(1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 3'd7);
    // Hold without ready, accept, then load into the empty slot while ready is low.
    tbl[25] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd7);
    tbl[26] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd7);
    tbl[27] = mk(1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 3'd1);

    rst = 1'b1; en = 1'b0; mode = 1'b0; req = 8'h00; out_ready = 1'b0;
    #1;
    cmp("por valid", 32'(out_valid), 32'd0);
    cmp("por idx", 32'(out_idx), 32'd0);
    cmp("por onehot", 32'(out_onehot), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill the slot with idx 4 and hold it with out_ready=0, then assert reset between edges.
    step(mk(1'b1, 1'b0, 8'h10, 1'b0, 1'b1, 3'd4), 100);
    req = 8'h00;
    #2;
    rst = 1'b1;
    #1;
    cmp("async_rst valid", 32'(out_valid), 32'd0);
    cmp("async_rst idx", 32'(out_idx), 32'd0);
    cmp("async_rst onehot", 32'(out_onehot), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      step(tbl[i], i);
    end

    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL sb_leftover: got %0d entries, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
